fetch_bus_arbiter: RTL

FETCH_BUS_ARBITER -- requirements
Module: fetch_bus_arbiter

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_bus_arbiter_if.sv | 34 +++
 rtl/fetch_bus_arbiter_rr_arb2.sv | 40 ++++
 rtl/fetch_bus_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared fetch-core types: arbiter state encoding and way ownership.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef enum logic {
        WAY0 = 1'b0,
        WAY1 = 1'b1
    } owner_e;

    function automatic owner_e other_way(input owner_e w);
        return (w == WAY0) ? WAY1 : WAY0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_bus_arbiter_if
// Purpose  : Way-side fetch handshakes plus the shared instruction-bus signals.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_bus_arbiter_if #(
    parameter int AddrWidth = 32
);
    logic                 req0_i;
    logic                 req1_i;
    logic [AddrWidth-1:0] addr0_i;
    logic [AddrWidth-1:0] addr1_i;
    logic                 gnt0_o;
    logic                 gnt1_o;
    logic                 dataOk0_o;
    logic                 dataOk1_o;
    logic                 bus_req_o;
    logic [AddrWidth-1:0] bus_addr_o;
    logic                 bus_ready_i;
    logic                 bus_dataOk_i;

    // The arbiter itself takes the slave view; ways and bus model take master.
    modport slave (
        input  req0_i, req1_i, addr0_i, addr1_i, bus_ready_i, bus_dataOk_i,
        output gnt0_o, gnt1_o, dataOk0_o, dataOk1_o, bus_req_o, bus_addr_o
    );

    modport master (
        output req0_i, req1_i, addr0_i, addr1_i, bus_ready_i, bus_dataOk_i,
        input  gnt0_o, gnt1_o, dataOk0_o, dataOk1_o, bus_req_o, bus_addr_o
    );
endinterface
`default_nettype wire

// File: rtl/fetch_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin select with a registered priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import fetch_pkg::*;
(
    input  wire    clk,
    input  wire    reset_n,
    input  wire    req0_i,
    input  wire    req1_i,
    input  wire    advance_i,
    input  wire    owner_i,
    output owner_e grant_o
);

    owner_e r_pointer;

    // Pointer only moves past a way once that way's fetch actually completed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pointer <= WAY0;
        end else if (advance_i) begin
            r_pointer <= other_way(owner_e'(owner_i));
        end
    end

    always_comb begin
        grant_o = r_pointer;
        if (req0_i && !req1_i) begin
            grant_o = WAY0;
        end else if (req1_i && !req0_i) begin
            grant_o = WAY1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_bus_arbiter
// Purpose  : Shares one instruction bus between two fetch ways with flush
//            drain and a WAIT/DRAIN timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_bus_arbiter
    import fetch_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int TimeoutCycles = 255
) (
    input  wire                clk,
    input  wire                reset_n,
    input  wire                flush_i,
    output logic               busy_o,
    output logic               timeout_o,
    fetch_bus_arbiter_if.slave bus_if
);

    localparam int                 c_CNT_W   = $clog2(TimeoutCycles + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TimeoutCycles);

    fetch_state_e         r_state;
    fetch_state_e         w_state_next;
    owner_e               r_owner;
    owner_e               w_grant;
    logic [AddrWidth-1:0] r_bus_addr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_take;
    logic                 w_counting;
    logic                 w_enter_count;
    logic                 w_timeout;
    logic                 w_gnt;
    logic                 w_data_ok;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0_i    (bus_if.req0_i),
        .req1_i    (bus_if.req1_i),
        .advance_i (w_data_ok),
        .owner_i   (r_owner),
        .grant_o   (w_grant)
    );

    assign w_take        = (r_state == ST_IDLE) && (bus_if.req0_i || bus_if.req1_i);
    assign w_counting    = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign w_timeout     = w_counting && (r_cnt == c_CNT_MAX);
    assign w_enter_count = (w_state_next != r_state) &&
                           ((w_state_next == ST_WAIT) || (w_state_next == ST_DRAIN));

    // Timeout outranks a coincident data strobe; flush only matters in REQ/WAIT.
    always_comb begin
        w_state_next = r_state;
        w_gnt        = 1'b0;
        w_data_ok    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_if.bus_ready_i) begin
                    if (flush_i) begin
                        w_state_next = ST_DRAIN;
                    end else begin
                        w_gnt        = 1'b1;
                        w_state_next = ST_WAIT;
                    end
                end else if (flush_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end else if (bus_if.bus_dataOk_i) begin
                    w_data_ok    = !flush_i;
                    w_state_next = ST_IDLE;
                end else if (flush_i) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_timeout || bus_if.bus_dataOk_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_owner    <= WAY0;
            r_bus_addr <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_owner    <= w_grant;
                r_bus_addr <= (w_grant == WAY1) ? bus_if.addr1_i : bus_if.addr0_i;
            end
            if (w_enter_count) begin
                r_cnt <= '0;
            end else if (w_counting && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign bus_if.gnt0_o     = w_gnt && (r_owner == WAY0);
    assign bus_if.gnt1_o     = w_gnt && (r_owner == WAY1);
    assign bus_if.dataOk0_o  = w_data_ok && (r_owner == WAY0);
    assign bus_if.dataOk1_o  = w_data_ok && (r_owner == WAY1);
    assign bus_if.bus_req_o  = (r_state == ST_REQ);
    assign bus_if.bus_addr_o = r_bus_addr;
    assign busy_o            = (r_state != ST_IDLE);
    assign timeout_o         = w_timeout;

endmodule
`default_nettype wire
